// File: rtl/ventana_pixeles_param.sv
// Streaming sliding-window generator: four circular line memories feed a 5x5 shift window
// (3x3 in the lower-right corner when modo_5x5=0); frame size is configured at start.
module ventana_pixeles_param #(
    parameter int BITS_PIXEL = 8,
    parameter int MAX_ANCHO  = 1024,
    parameter int BITS_DIM   = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      modo_5x5,
    input  logic [BITS_DIM-1:0]       ancho_linea,
    input  logic [BITS_DIM-1:0]       alto_imagen,
    input  logic                      data_available,
    input  logic [BITS_PIXEL-1:0]     pixel_in,
    output logic [25*BITS_PIXEL-1:0]  ventana,
    output logic                      ventana_valida,
    output logic                      ocupado,
    output logic                      fin,
    output logic                      error_config
);

    localparam int ADDR_W = (MAX_ANCHO > 1) ? $clog2(MAX_ANCHO) : 1;
    localparam logic [BITS_DIM-1:0] DIM_UNO = BITS_DIM'(1);

    typedef enum logic [1:0] {REPOSO, CAPTURA, FIN} estado_t;

    estado_t               r_estado;
    logic                  r_modo5;
    logic [BITS_DIM-1:0]   r_ancho;
    logic [BITS_DIM-1:0]   r_alto;
    logic [BITS_DIM-1:0]   r_fila;
    logic [BITS_DIM-1:0]   r_col;
    logic                  r_valida;
    logic                  r_fin;
    logic                  r_error;
    logic [BITS_PIXEL-1:0] r_win [5][5];

    logic [BITS_PIXEL-1:0] w_lm_out [4];
    logic [BITS_PIXEL-1:0] w_col_in [5];
    logic                  w_acepta;
    logic                  w_cfg_ok;
    logic                  w_ult_col;
    logic                  w_ult_fila;
    logic                  w_en_ventana;
    logic [BITS_DIM-1:0]   w_k_in;
    logic [BITS_DIM-1:0]   w_km1;
    logic [ADDR_W-1:0]     w_ptr;

    assign w_acepta     = (r_estado == CAPTURA) && data_available;
    assign w_k_in       = modo_5x5 ? BITS_DIM'(5) : BITS_DIM'(3);
    assign w_cfg_ok     = (ancho_linea >= w_k_in) && (int'(ancho_linea) <= MAX_ANCHO) &&
                          (alto_imagen >= w_k_in);
    assign w_km1        = r_modo5 ? BITS_DIM'(4) : BITS_DIM'(2);
    assign w_ult_col    = (r_col == r_ancho - DIM_UNO);
    assign w_ult_fila   = (r_fila == r_alto - DIM_UNO);
    assign w_en_ventana = (r_fila >= w_km1) && (r_col >= w_km1);
    // The line pointer wraps exactly like the column counter, so it is the column itself.
    assign w_ptr        = r_col[ADDR_W-1:0];

    genvar gi, gc;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_linea
            logic [BITS_PIXEL-1:0] r_mem [MAX_ANCHO];
            logic [BITS_PIXEL-1:0] w_din;
            if (gi == 0) begin : g_primera
                assign w_din = pixel_in;
            end else begin : g_cadena
                assign w_din = w_lm_out[gi-1];
            end
            assign w_lm_out[gi] = r_mem[w_ptr];
            always_ff @(posedge clk) begin
                if (w_acepta) begin
                    r_mem[w_ptr] <= w_din;
                end
            end
        end

        assign w_col_in[4] = pixel_in;
        for (gi = 0; gi < 4; gi++) begin : g_col_in
            assign w_col_in[gi] = w_lm_out[3-gi];
        end

        // Entries outside the lower-right 3x3 are forced to zero in 3x3 mode.
        for (gi = 0; gi < 5; gi++) begin : g_fila_out
            for (gc = 0; gc < 5; gc++) begin : g_col_out
                if (gi >= 2 && gc >= 2) begin : g_nucleo
                    assign ventana[(gi*5+gc)*BITS_PIXEL +: BITS_PIXEL] = r_win[gi][gc];
                end else begin : g_borde
                    assign ventana[(gi*5+gc)*BITS_PIXEL +: BITS_PIXEL] =
                        r_modo5 ? r_win[gi][gc] : '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_acepta) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][4] <= w_col_in[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado <= REPOSO;
            r_modo5  <= 1'b0;
            r_ancho  <= '0;
            r_alto   <= '0;
            r_fila   <= '0;
            r_col    <= '0;
            r_valida <= 1'b0;
            r_fin    <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_valida <= 1'b0;
            r_fin    <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (iniciar) begin
                        if (w_cfg_ok) begin
                            r_modo5  <= modo_5x5;
                            r_ancho  <= ancho_linea;
                            r_alto   <= alto_imagen;
                            r_fila   <= '0;
                            r_col    <= '0;
                            r_error  <= 1'b0;
                            r_estado <= CAPTURA;
                        end else begin
                            r_error  <= 1'b1;
                        end
                    end
                end
                CAPTURA: begin
                    if (data_available) begin
                        r_valida <= w_en_ventana;
                        if (w_ult_col) begin
                            r_col  <= '0;
                            r_fila <= r_fila + DIM_UNO;
                            if (w_ult_fila) begin
                                r_estado <= FIN;
                                r_fin    <= 1'b1;
                            end
                        end else begin
                            r_col <= r_col + DIM_UNO;
                        end
                    end
                end
                FIN: begin
                    r_estado <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                end
            endcase
        end
    end

    assign ventana_valida = r_valida;
    assign fin            = r_fin;
    assign error_config   = r_error;
    assign ocupado        = (r_estado != REPOSO);

endmodule
